tone_divider: RTL and testbench

- Programmable tone generator sitting directly downstream of the note-index-to-frequency-code lookup.
- Consumes the 11-bit frequency code F_CODE and produces the square-wave speaker drive SPKS.
- Structure: parameterised clock prescaler, then an 11-bit reloadable up-counter, then a toggle flip-flop.
- Code 11'h7FF means rest (silence).
- F_CODE is sampled only at period boundaries, so note changes never produce runt half-periods.

---
 rtl/tone_divider.sv | 62 ++++++
 tb/tb_tone_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tone_divider.sv
// Programmable tone generator: clock prescaler feeding a reloadable up-counter
// whose terminal count toggles the speaker square wave. All-ones code means rest.
module tone_divider #(
  parameter int CODE_W  = 11,
  parameter int PRE_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [CODE_W-1:0] F_CODE,
  output logic              SPKS,
  output logic              FULL,
  output logic              REST
);

  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [CODE_W-1:0] ALL_ONES = '1;

  logic [PRE_W-1:0]  pre;
  logic [CODE_W-1:0] cnt;
  logic [CODE_W-1:0] code_q;
  logic              tick;

  assign tick = EN && (pre == PRE_LAST);

  // REST follows the latched code, so it only changes at terminal counts.
  assign REST = &code_q;

  // F_CODE is only sampled at a terminal count, so every half-period completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre    <= '0;
      cnt    <= ALL_ONES;
      code_q <= ALL_ONES;
      SPKS   <= 1'b0;
      FULL   <= 1'b0;
    end else if (!EN) begin
      pre  <= '0;
      SPKS <= 1'b0;
      FULL <= 1'b0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      FULL <= 1'b0;
      if (tick) begin
        if (cnt == ALL_ONES) begin
          cnt    <= F_CODE;
          code_q <= F_CODE;
          if (F_CODE != ALL_ONES) begin
            SPKS <= ~SPKS;
            FULL <= 1'b1;
          end else begin
            SPKS <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_divider.sv
// Self-checking bench for tone_divider: directed period scenarios plus random
// stimulus compared each cycle against a ticks-remaining reference model.
module tb_tone_divider;

  localparam int ALL1 = 2047;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [10:0] f_code = 11'h7FF;
  logic        spks4, full4, rest4;
  logic        spks1, full1, rest1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tone_divider #(.CODE_W(11), .PRE_DIV(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .F_CODE(f_code),
    .SPKS(spks4), .FULL(full4), .REST(rest4)
  );

  tone_divider #(.CODE_W(11), .PRE_DIV(1)) dut1 (
    .CLK(clk), .RST(rst), .EN(en), .F_CODE(f_code),
    .SPKS(spks1), .FULL(full1), .REST(rest1)
  );

  // Model tracks enabled edges within a prescale period and ticks left to terminal.
  typedef struct {
    int pre;
    int remain;
    bit spks;
    bit full;
    bit rest;
  } model_t;

  model_t m4, m1;

  function automatic model_t model_step(model_t m, bit r, bit e, int code, int pre_div);
    model_t n = m;
    bit tick;
    if (r) begin
      n.pre = 0; n.remain = 0; n.spks = 0; n.full = 0; n.rest = 1;
    end else if (!e) begin
      n.pre = 0; n.spks = 0; n.full = 0;
    end else begin
      tick = (m.pre == pre_div - 1);
      n.pre = tick ? 0 : m.pre + 1;
      n.full = 0;
      if (tick) begin
        if (m.remain == 0) begin
          n.rest = (code == ALL1);
          if (code == ALL1) begin
            n.spks = 0;
            n.remain = 0;
          end else begin
            n.spks = !m.spks;
            n.full = 1;
            n.remain = ALL1 - code;
          end
        end else begin
          n.remain = m.remain - 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 = model_step(m4, rst, en, int'(f_code), 4);
    m1 = model_step(m1, rst, en, int'(f_code), 1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [10:0] c);
    rst = r;
    en = e;
    f_code = c;
    @(posedge clk);
    #1;
    checkOutput("spks4", 32'(spks4), 32'(m4.spks));
    checkOutput("full4", 32'(full4), 32'(m4.full));
    checkOutput("rest4", 32'(rest4), 32'(m4.rest));
    checkOutput("spks1", 32'(spks1), 32'(m1.spks));
    checkOutput("full1", 32'(full1), 32'(m1.full));
    checkOutput("rest1", 32'(rest1), 32'(m1.rest));
  endtask

  initial begin
    int full_at[$];
    int edge_at[$];
    int cnt_full, cnt_spks;
    bit prev;
    logic [10:0] code;

    // Reset state
    applyStimulus(1, 0, 11'h7FF);
    checkOutput("reset_spks", 32'(spks4), 0);
    checkOutput("reset_full", 32'(full4), 0);
    checkOutput("reset_rest", 32'(rest4), 1);

    // Steady tone 7FD: FULL after the 4th enabled edge, then every 12 CLK
    applyStimulus(1, 1, 11'h7FD);
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(0, 1, 11'h7FD);
      if (full4) full_at.push_back(i);
    end
    checkOutput("full_count", full_at.size(), 5);
    if (full_at.size() > 0) checkOutput("first_full", full_at[0], 4);
    for (int i = 1; i < full_at.size(); i++)
      checkOutput("full_spacing", full_at[i] - full_at[i-1], 12);

    // Rest from reset for 200 cycles: silent
    applyStimulus(1, 1, 11'h7FF);
    cnt_full = 0;
    cnt_spks = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 1, 11'h7FF);
      cnt_full += int'(full4);
      cnt_spks += int'(spks4);
    end
    checkOutput("rest_full_count", cnt_full, 0);
    checkOutput("rest_spks_count", cnt_spks, 0);
    checkOutput("rest_flag", 32'(rest4), 1);

    // Leave rest with 7FE: PRE_DIV=1 toggles every 2 CLK, PRE_DIV=4 every 8
    prev = spks1;
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(0, 1, 11'h7FE);
      if (spks1 != prev) edge_at.push_back(i);
      prev = spks1;
    end
    checkOutput("pre1_edges", edge_at.size(), 12);
    for (int i = 1; i < edge_at.size(); i++)
      checkOutput("pre1_spacing", edge_at[i] - edge_at[i-1], 2);

    // Mid half-period code change, EN gap and reset pulse, checked by the model
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 11'h7FD);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, 11'h7FA);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 11'h7FD);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, 11'h7FD);
    applyStimulus(1, 1, 11'h7FD);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 11'h7FD);

    // Random stimulus
    code = 11'h7F0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        code = ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'($urandom_range(11'h7E8, 11'h7FE));
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
